// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one data_cache CPU port between two MEM-stage lanes.
// Optional macro DCACHE_ARB_PERF_EN adds per-lane completion and conflict counters.
module dcache_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RR     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [2:0]        funct3_0_i,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [2:0]        funct3_1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall0_o,
   output logic              stall1_o,
   output logic              cpu_req_o,
   output logic              cpu_we_o,
   output logic [ADDR_W-1:0] cpu_addr_o,
   output logic [DATA_W-1:0] cpu_wdata_o,
   output logic [2:0]        cpu_funct3_o,
   input  logic [DATA_W-1:0] cpu_rdata_i,
`ifdef DCACHE_ARB_PERF_EN
   output logic [31:0]       perf_gnt0_o,
   output logic [31:0]       perf_gnt1_o,
   output logic [31:0]       perf_conflict_o,
`endif
   input  logic              cpu_stall_i
);
   typedef enum logic {IDLE, LOCK} state_t;
   state_t              r_state, w_next;
   logic                r_gnt, r_rr_ptr;
   logic                r_hold_we;
   logic [ADDR_W-1:0]   r_hold_addr;
   logic [DATA_W-1:0]   r_hold_wdata;
   logic [2:0]          r_hold_funct3;
   logic                w_lock, w_win, w_id, w_done, w_capture;
   always_comb begin
      w_lock       = r_state == LOCK;
      w_win        = (req0_i & req1_i) ? ((RR != 0) ? r_rr_ptr : 1'b0) : req1_i;
      w_id         = w_lock ? r_gnt : w_win;
      cpu_req_o    = w_lock | req0_i | req1_i;
      w_done       = cpu_req_o & ~cpu_stall_i;
      w_capture    = ~w_lock & cpu_req_o & cpu_stall_i;
      // Idle with no request drives zeros so the cache sees a quiet bus
      cpu_we_o     = w_lock ? r_hold_we     : cpu_req_o & (w_win ? we1_i : we0_i);
      cpu_addr_o   = w_lock ? r_hold_addr   : !cpu_req_o ? '0 : (w_win ? addr1_i : addr0_i);
      cpu_wdata_o  = w_lock ? r_hold_wdata  : !cpu_req_o ? '0 : (w_win ? wdata1_i : wdata0_i);
      cpu_funct3_o = w_lock ? r_hold_funct3 : !cpu_req_o ? '0 : (w_win ? funct3_1_i : funct3_0_i);
      ack0_o       = w_done & ~w_id;
      ack1_o       = w_done & w_id;
      stall0_o     = req0_i & ~ack0_o;
      stall1_o     = req1_i & ~ack1_o;
      rdata_o      = cpu_rdata_i;
      w_next       = w_lock ? (w_done ? IDLE : LOCK) : (w_capture ? LOCK : IDLE);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_gnt         <= 1'b0;
         r_rr_ptr      <= 1'b0;
         r_hold_we     <= 1'b0;
         r_hold_addr   <= '0;
         r_hold_wdata  <= '0;
         r_hold_funct3 <= '0;
      end else begin
         r_state <= w_next;
         if (w_done) r_rr_ptr <= ~w_id;
         if (w_capture) begin
            r_gnt         <= w_win;
            r_hold_we     <= cpu_we_o;
            r_hold_addr   <= cpu_addr_o;
            r_hold_wdata  <= cpu_wdata_o;
            r_hold_funct3 <= cpu_funct3_o;
         end
      end
   end
`ifdef DCACHE_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_gnt0_o     <= '0;
         perf_gnt1_o     <= '0;
         perf_conflict_o <= '0;
      end else begin
         if (ack0_o) perf_gnt0_o <= perf_gnt0_o + 32'd1;
         if (ack1_o) perf_gnt1_o <= perf_gnt1_o + 32'd1;
         if (req0_i & req1_i) perf_conflict_o <= perf_conflict_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed and randomized checks of the two-lane cache port arbiter.
// Runs a round-robin instance and a fixed-priority instance side by side on shared stimulus.
module tb_dcache_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0, we0, req1, we1, stall;
   logic [31:0] addr0, addr1, wd0, wd1, rd;
   logic [2:0]  f0, f1;
   logic        a_ack0, a_ack1, a_st0, a_st1, a_creq, a_cwe;
   logic        b_ack0, b_ack1, b_st0, b_st1, b_creq, b_cwe;
   logic [31:0] a_rdata, a_caddr, a_cwd, b_rdata, b_caddr, b_cwd;
   logic [2:0]  a_cf3, b_cf3;
`ifdef DCACHE_ARB_PERF_EN
   logic [31:0] a_pg0, a_pg1, a_pc, b_pg0, b_pg1, b_pc;
`endif
   int checks = 0;
   int errors = 0;
   int          owner [2];
   int          prio  [2];
   logic        h_we  [2];
   logic [31:0] h_addr[2];
   logic [31:0] h_wd  [2];
   logic [2:0]  h_f3  [2];
   always #5 clk = ~clk;

   dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1)) u_rr (
      .clk(clk), .rst(rst),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wd0), .funct3_0_i(f0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wd1), .funct3_1_i(f1),
      .ack0_o(a_ack0), .ack1_o(a_ack1), .rdata_o(a_rdata), .stall0_o(a_st0), .stall1_o(a_st1),
      .cpu_req_o(a_creq), .cpu_we_o(a_cwe), .cpu_addr_o(a_caddr), .cpu_wdata_o(a_cwd),
      .cpu_funct3_o(a_cf3), .cpu_rdata_i(rd),
`ifdef DCACHE_ARB_PERF_EN
      .perf_gnt0_o(a_pg0), .perf_gnt1_o(a_pg1), .perf_conflict_o(a_pc),
`endif
      .cpu_stall_i(stall));

   dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(0)) u_fp (
      .clk(clk), .rst(rst),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wd0), .funct3_0_i(f0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wd1), .funct3_1_i(f1),
      .ack0_o(b_ack0), .ack1_o(b_ack1), .rdata_o(b_rdata), .stall0_o(b_st0), .stall1_o(b_st1),
      .cpu_req_o(b_creq), .cpu_we_o(b_cwe), .cpu_addr_o(b_caddr), .cpu_wdata_o(b_cwd),
      .cpu_funct3_o(b_cf3), .cpu_rdata_i(rd),
`ifdef DCACHE_ARB_PERF_EN
      .perf_gnt0_o(b_pg0), .perf_gnt1_o(b_pg1), .perf_conflict_o(b_pc),
`endif
      .cpu_stall_i(stall));

   task automatic idle_inputs();
      req0 = 0; we0 = 0; addr0 = 0; wd0 = 0; f0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wd1 = 0; f1 = 0;
      stall = 0; rd = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 0;
      tick();
      rst = 1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (a_creq !== 1'b0) begin errors++; $display("FAIL reset_creq got %0b exp 0", a_creq); end
      checks++; if ({a_ack0, a_ack1, b_ack0, b_ack1} !== 4'b0) begin errors++; $display("FAIL reset_acks got %b exp 0000", {a_ack0, a_ack1, b_ack0, b_ack1}); end
      checks++; if ({a_st0, a_st1} !== 2'b0) begin errors++; $display("FAIL reset_stalls got %b exp 00", {a_st0, a_st1}); end
      checks++; if (a_caddr !== 32'h0) begin errors++; $display("FAIL reset_caddr got %h exp 0", a_caddr); end
      tick();
   endtask

   task automatic test_single_hit();
      do_reset();
      req0 = 1; addr0 = 32'h100; rd = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (a_ack0 !== 1'b1) begin errors++; $display("FAIL hit_ack0 got %0b exp 1", a_ack0); end
      checks++; if (a_caddr !== 32'h100) begin errors++; $display("FAIL hit_caddr got %h exp 100", a_caddr); end
      checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_rdata got %h exp deadbeef", a_rdata); end
      checks++; if (a_st0 !== 1'b0) begin errors++; $display("FAIL hit_stall0 got %0b exp 0", a_st0); end
      checks++; if (a_creq !== 1'b1) begin errors++; $display("FAIL hit_creq got %0b exp 1", a_creq); end
      tick();
      idle_inputs();
   endtask

   task automatic test_contended();
      do_reset();
      req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
      @(negedge clk);
      checks++; if ({a_ack0, a_ack1} !== 2'b10) begin errors++; $display("FAIL cont0_acks got %b exp 10", {a_ack0, a_ack1}); end
      checks++; if (a_caddr !== 32'h10) begin errors++; $display("FAIL cont0_caddr got %h exp 10", a_caddr); end
      checks++; if (a_st1 !== 1'b1) begin errors++; $display("FAIL cont0_stall1 got %0b exp 1", a_st1); end
      tick();
      @(negedge clk);
      checks++; if ({a_ack0, a_ack1} !== 2'b01) begin errors++; $display("FAIL cont1_acks got %b exp 01", {a_ack0, a_ack1}); end
      checks++; if (a_caddr !== 32'h20) begin errors++; $display("FAIL cont1_caddr got %h exp 20", a_caddr); end
      checks++; if (a_st0 !== 1'b1) begin errors++; $display("FAIL cont1_stall0 got %0b exp 1", a_st0); end
      checks++; if ({b_ack0, b_ack1} !== 2'b10) begin errors++; $display("FAIL cont1_fixed_acks got %b exp 10", {b_ack0, b_ack1}); end
      tick();
      @(negedge clk);
      checks++; if ({a_ack0, a_ack1} !== 2'b10) begin errors++; $display("FAIL cont2_rrptr_acks got %b exp 10", {a_ack0, a_ack1}); end
      tick();
      idle_inputs();
   endtask

   task automatic test_miss_lock();
      do_reset();
      req1 = 1; we1 = 1; addr1 = 32'h40; wd1 = 32'h55; f1 = 3'd2; stall = 1;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin req0 = 1; addr0 = 32'h99; addr1 = 32'h80; wd1 = 32'h77; end
         if (c == 4) stall = 0;
         @(negedge clk);
         checks++; if ({a_caddr, a_cwd, a_cwe, a_cf3} !== {32'h40, 32'h55, 1'b1, 3'd2}) begin errors++; $display("FAIL miss_c%0d_bus got %h/%h/%0b/%0d exp 40/55/1/2", c, a_caddr, a_cwd, a_cwe, a_cf3); end
         checks++; if (a_ack1 !== (c == 4)) begin errors++; $display("FAIL miss_c%0d_ack1 got %0b exp %0b", c, a_ack1, c == 4); end
         checks++; if ({a_ack0, a_st0} !== {1'b0, req0}) begin errors++; $display("FAIL miss_c%0d_lane0 got %b exp 0%0b", c, {a_ack0, a_st0}, req0); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_fixed_prio();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         req0 = 1; req1 = 1; addr0 = $urandom; addr1 = $urandom;
         @(negedge clk);
         checks++; if ({b_ack0, b_ack1} !== 2'b10) begin errors++; $display("FAIL fixed_c%0d_acks got %b exp 10", c, {b_ack0, b_ack1}); end
         checks++; if (b_caddr !== addr0) begin errors++; $display("FAIL fixed_c%0d_caddr got %h exp %h", c, b_caddr, addr0); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      req0 = 1; addr0 = 32'h200;
      tick();
      req0 = 0; req1 = 1; addr1 = 32'h300; stall = 1;
      tick();
      rst = 0;
      @(negedge clk);
      checks++; if ({a_ack0, a_ack1} !== 2'b00) begin errors++; $display("FAIL rstlock_acks got %b exp 00", {a_ack0, a_ack1}); end
      checks++; if (a_caddr !== 32'h300) begin errors++; $display("FAIL rstlock_caddr got %h exp 300", a_caddr); end
      tick();
      rst = 1; req0 = 1; addr0 = 32'h204; stall = 0;
      @(negedge clk);
      checks++; if ({a_creq, a_caddr} !== {1'b1, 32'h204}) begin errors++; $display("FAIL rstlock_after_bus got %0b/%h exp 1/204", a_creq, a_caddr); end
      checks++; if ({a_ack0, a_ack1} !== 2'b10) begin errors++; $display("FAIL rstlock_after_acks got %b exp 10", {a_ack0, a_ack1}); end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      int          e_id  [2];
      logic        e_req [2];
      logic        e_done[2];
      logic        e_we  [2];
      logic [31:0] e_a   [2];
      logic [31:0] e_w   [2];
      logic [2:0]  e_f   [2];
      do_reset();
      for (int m = 0; m < 2; m++) begin
         owner[m] = -1; prio[m] = 0; h_we[m] = 0; h_addr[m] = 0; h_wd[m] = 0; h_f3[m] = 0;
      end
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 39) != 0);
         req0 = ($urandom_range(0, 9) < 6); req1 = ($urandom_range(0, 9) < 6);
         we0 = $urandom; we1 = $urandom;
         addr0 = $urandom_range(0, 15) << 2; addr1 = $urandom_range(0, 15) << 2;
         wd0 = $urandom; wd1 = $urandom; f0 = $urandom; f1 = $urandom;
         stall = ($urandom_range(0, 9) < 3); rd = $urandom;
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            logic [104:0] exp_v, obs_v;
            logic ea0, ea1;
            if (owner[m] >= 0) begin
               e_id[m] = owner[m]; e_req[m] = 1;
               e_we[m] = h_we[m]; e_a[m] = h_addr[m]; e_w[m] = h_wd[m]; e_f[m] = h_f3[m];
            end else if (req0 || req1) begin
               e_id[m] = (req0 && req1) ? ((m == 0) ? prio[m] : 0) : (req1 ? 1 : 0);
               e_req[m] = 1;
               e_we[m] = e_id[m] == 1 ? we1 : we0;
               e_a[m]  = e_id[m] == 1 ? addr1 : addr0;
               e_w[m]  = e_id[m] == 1 ? wd1 : wd0;
               e_f[m]  = e_id[m] == 1 ? f1 : f0;
            end else begin
               e_id[m] = -1; e_req[m] = 0; e_we[m] = 0; e_a[m] = 0; e_w[m] = 0; e_f[m] = 0;
            end
            e_done[m] = e_req[m] && !stall;
            ea0 = e_done[m] && e_id[m] == 0;
            ea1 = e_done[m] && e_id[m] == 1;
            exp_v = {e_req[m], e_we[m], e_a[m], e_w[m], e_f[m], ea0, ea1, req0 & ~ea0, req1 & ~ea1, rd};
            obs_v = (m == 0) ? {a_creq, a_cwe, a_caddr, a_cwd, a_cf3, a_ack0, a_ack1, a_st0, a_st1, a_rdata}
                             : {b_creq, b_cwe, b_caddr, b_cwd, b_cf3, b_ack0, b_ack1, b_st0, b_st1, b_rdata};
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL rand_m%0d_c%0d got %h exp %h", m, c, obs_v, exp_v); end
         end
         @(posedge clk);
         for (int m = 0; m < 2; m++) begin
            if (!rst) begin
               owner[m] = -1; prio[m] = 0; h_we[m] = 0; h_addr[m] = 0; h_wd[m] = 0; h_f3[m] = 0;
            end else if (e_done[m]) begin
               owner[m] = -1; prio[m] = 1 - e_id[m];
            end else if (e_req[m] && owner[m] < 0) begin
               owner[m] = e_id[m]; h_we[m] = e_we[m]; h_addr[m] = e_a[m]; h_wd[m] = e_w[m]; h_f3[m] = e_f[m];
            end
         end
         #1;
      end
      rst = 1;
      idle_inputs();
   endtask

`ifdef DCACHE_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
      for (int c = 0; c < 6; c++) tick();
      idle_inputs();
      @(negedge clk);
      checks++; if ({a_pg0, a_pg1, a_pc} !== {32'd3, 32'd3, 32'd6}) begin errors++; $display("FAIL perf_rr got %0d/%0d/%0d exp 3/3/6", a_pg0, a_pg1, a_pc); end
      checks++; if ({b_pg0, b_pg1, b_pc} !== {32'd6, 32'd0, 32'd6}) begin errors++; $display("FAIL perf_fixed got %0d/%0d/%0d exp 6/0/6", b_pg0, b_pg1, b_pc); end
      tick();
   endtask
`endif

   initial begin
      rst = 0;
      idle_inputs();
      #1;
      test_reset();
      test_single_hit();
      test_contended();
      test_miss_lock();
      test_fixed_prio();
      test_reset_mid_lock();
      test_random();
`ifdef DCACHE_ARB_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
